// File: rtl/dice_pkg.sv
// Shared encodings for the two-player dice game controller: FSM states,
// throw/winner result codes and the fixed settle time.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROLL   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_JUDGE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // winner uses the same codes; RES_TIE never appears there
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_A    = 2'b01,
    RES_B    = 2'b10,
    RES_TIE  = 2'b11
  } result_e;

  localparam int unsigned SETTLE_CYC = 2;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector. RESET_VAL=1 treats a level already high
// at reset release as old, so a held button does not fire.
module edge_rise #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= RESET_VAL;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/dice_game_ctrl.sv
// Throw sequencer for two dice generators: strobed roll burst, settle,
// compare, score keeping to WIN_SCORE and a one-cycle finish strobe.
module dice_game_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned ROLL_TICKS = 8,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned WIN_SCORE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dice_a,
  input  logic [3:0] dice_b,
  output logic       roll_a,
  output logic       roll_b,
  output logic       finish,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [1:0] last_result,
  output logic [1:0] winner,
  output logic       busy
);

  localparam logic [3:0] ROLL_LAST   = 4'(ROLL_TICKS);
  localparam logic [7:0] DIV_LAST    = 8'(TICK_DIV - 1);
  localparam logic [3:0] WIN_C       = 4'(WIN_SCORE);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  settle_q, settle_d;
  logic        roll_q, roll_d;
  logic        finish_q, finish_d;
  logic        busy_q, busy_d;
  logic [3:0]  score_a_q, score_a_d;
  logic [3:0]  score_b_q, score_b_d;
  result_e     result_q, result_d;
  result_e     winner_q, winner_d;
  logic        start_rise;

  edge_rise #(.RESET_VAL(1'b1)) u_start_rise (
    .clk    (clk),
    .rst_n  (rst),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  // NOTE: every variable gets its hold/idle value before the case so no
  // path through the block leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    roll_d    = 1'b0;
    finish_d  = 1'b0;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    result_d  = result_q;
    winner_d  = winner_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_ROLL;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_ROLL: begin
        // cnt reaches ROLL_LAST while the last strobe is still high
        if (cnt_q == ROLL_LAST) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          roll_d = 1'b1;
          cnt_d  = cnt_q + 4'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_JUDGE;
        else                         settle_d = settle_q + 2'd1;
      end
      ST_JUDGE: begin
        state_d = ST_IDLE;
        if (dice_a > dice_b) begin
          score_a_d = score_a_q + 4'd1;
          result_d  = RES_A;
          if (score_a_d == WIN_C) winner_d = RES_A;
        end else if (dice_b > dice_a) begin
          score_b_d = score_b_q + 4'd1;
          result_d  = RES_B;
          if (score_b_d == WIN_C) winner_d = RES_B;
        end else begin
          result_d = RES_TIE;
        end
        if (winner_d != RES_NONE) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (start_rise) begin
          state_d   = ST_IDLE;
          score_a_d = '0;
          score_b_d = '0;
          result_d  = RES_NONE;
          winner_d  = RES_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ROLL) || (state_d == ST_SETTLE) || (state_d == ST_JUDGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      roll_q    <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      score_a_q <= '0;
      score_b_q <= '0;
      result_q  <= RES_NONE;
      winner_q  <= RES_NONE;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      roll_q    <= roll_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      result_q  <= result_d;
      winner_q  <= winner_d;
    end
  end

  assign roll_a      = roll_q;
  assign roll_b      = roll_q;
  assign finish      = finish_q;
  assign busy        = busy_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;
  assign last_result = result_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scoreboard bench for dice_game_ctrl: a game-level model queues the expected
// outcome of each throw; a monitor checks strobe timing and outcomes.
module tb_dice_game_ctrl;

  localparam int ROLL_TICKS = 8;
  localparam int TICK_DIV   = 4;
  localparam int WIN_SCORE  = 3;

  typedef struct {
    int       sa;
    int       sb;
    int       res;
    int       win;
    bit       fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dice_a, dice_b;
  logic       roll_a, roll_b, finish, busy;
  logic [3:0] score_a, score_b;
  logic [1:0] last_result, winner;

  int n_checks = 0;
  int n_err    = 0;

  exp_t exp_q[$];
  int   m_sa = 0, m_sb = 0, m_res = 0, m_win = 0;
  int   exp_finish = 0;

  bit   in_throw   = 0;
  int   idx        = 0;
  int   n_roll     = 0;
  int   bad_space  = 0;
  int   stray_roll = 0;
  int   viol       = 0;
  int   finish_seen = 0;

  dice_game_ctrl #(
    .ROLL_TICKS (ROLL_TICKS),
    .TICK_DIV   (TICK_DIV),
    .WIN_SCORE  (WIN_SCORE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dice_a      (dice_a),
    .dice_b      (dice_b),
    .roll_a      (roll_a),
    .roll_b      (roll_b),
    .finish      (finish),
    .score_a     (score_a),
    .score_b     (score_b),
    .last_result (last_result),
    .winner      (winner),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules: higher die scores a point, first to WIN_SCORE wins.
  task automatic model_throw(input int a, input int b);
    exp_t e;
    if (a > b) begin m_sa++; m_res = 1; end
    else if (b > a) begin m_sb++; m_res = 2; end
    else m_res = 3;
    if (m_sa == WIN_SCORE) m_win = 1;
    else if (m_sb == WIN_SCORE) m_win = 2;
    e.sa = m_sa; e.sb = m_sb; e.res = m_res; e.win = m_win; e.fin = (m_win != 0);
    if (e.fin) exp_finish++;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    m_sa = 0; m_sb = 0; m_res = 0; m_win = 0;
  endtask

  // Monitor: samples on the falling edge, judges each throw when busy drops.
  always @(negedge clk) begin
    if (!rst) begin
      in_throw = 0;
    end else begin
      if (roll_a !== roll_b) viol++;
      if (roll_a && finish) viol++;
      if (finish) finish_seen++;
      if (busy) begin
        if (!in_throw) begin
          in_throw = 1; idx = 0; n_roll = 0; bad_space = 0;
        end
        if (roll_a) begin
          if (idx != TICK_DIV * (n_roll + 1)) bad_space++;
          n_roll++;
        end
        idx++;
      end else if (in_throw) begin
        in_throw = 0;
        check("roll_count", n_roll, ROLL_TICKS);
        check("roll_spacing", bad_space, 0);
        check("busy_len", idx, ROLL_TICKS * TICK_DIV + 4);
        if (exp_q.size() == 0) begin
          check("unexpected_throw", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("score_a", score_a, e.sa);
          check("score_b", score_b, e.sb);
          check("last_result", last_result, e.res);
          check("winner", winner, e.win);
          check("finish_on_win", finish, e.fin);
        end
      end else if (roll_a) begin
        stray_roll++;
      end
    end
  end

  task automatic do_throw(input logic [3:0] a, input logic [3:0] b, input bit noisy);
    bit done;
    dice_a = a;
    dice_b = b;
    model_throw(a, b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (noisy) begin
        if (k == 10 || k == 33) start = 1'b1;
        if (k == 12 || k == 34) start = 1'b0;
      end
      if (!busy) begin
        done = 1;
        break;
      end
    end
    start = 1'b0;
    if (!done) check("throw_timeout", 0, 1);
  endtask

  task automatic do_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("clr_score_a", score_a, 0);
    check("clr_score_b", score_b, 0);
    check("clr_winner", winner, 0);
    check("clr_last_result", last_result, 0);
    check("clr_busy", busy, 0);
  endtask

  initial begin
    int seen;
    logic [3:0] ra, rb;
    rst    = 1'b0;
    start  = 1'b1;
    dice_a = 4'd0;
    dice_b = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_busy", busy, 0);
    check("hold_roll", roll_a, 0);
    check("hold_finish", finish, 0);
    check("hold_score_a", score_a, 0);
    check("hold_score_b", score_b, 0);
    check("hold_last_result", last_result, 0);
    check("hold_winner", winner, 0);
    start = 1'b0;
    @(negedge clk);

    do_throw(4'd7, 4'd3, 0);
    do_throw(4'd5, 4'd5, 0);
    repeat (3) do_throw(4'd2, 4'd9, 0);
    repeat (3) @(negedge clk);
    check("done_finish_low", finish, 0);
    check("done_busy_low", busy, 0);
    do_clear();

    do_throw(4'd8, 4'd1, 1);
    do_throw(4'd3, 4'd6, 1);

    // Abort a throw after its fifth strobe.
    dice_a = 4'd9;
    dice_b = 4'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int k = 0; k < 100 && seen < 5; k++) begin
      @(negedge clk);
      if (roll_a) seen++;
    end
    check("abort_reached_5", seen, 5);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_roll", roll_a, 0);
    check("abort_score_a", score_a, 0);
    check("abort_score_b", score_b, 0);
    check("abort_last_result", last_result, 0);
    check("abort_winner", winner, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_throw(4'd9, 4'd4, 0);

    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) rb = ra;
      do_throw(ra, rb, $urandom_range(0, 3) == 0);
      if (m_win != 0) do_clear();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("stray_rolls", stray_roll, 0);
    check("strobe_rules", viol, 0);
    check("finish_pulses", finish_seen, exp_finish);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
